// File: rtl/aes_uart_frame_ctrl_if.sv
// UART RX/TX and AES core signal bundle for the frame controller.
// The master modport is the controller side; the slave modport is the UART/core side.
interface aes_uart_frame_ctrl_if #(
   parameter int BLOCK_BITS = 128,
   parameter int KEY_BITS   = 128
) ();
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  tx_ready;
   logic                  tx_start;
   logic [7:0]            tx_data;
   logic [KEY_BITS-1:0]   key_out;
   logic [BLOCK_BITS-1:0] block_out;
   logic                  aes_start;
   logic                  aes_done;
   logic [BLOCK_BITS-1:0] aes_result;

   modport master (
      input  rx_data, rx_valid, tx_ready, aes_done, aes_result,
      output tx_start, tx_data, key_out, block_out, aes_start
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, aes_done, aes_result,
      input  tx_start, tx_data, key_out, block_out, aes_start
   );
endinterface

// File: rtl/aes_uart_frame_ctrl.sv
// UART byte-stream framer for an AES core: key + block collection, core start, paced result return.
// Optional mid-frame RX silence timeout is enabled by defining AES_UART_RX_TIMEOUT_EN.
module aes_uart_frame_ctrl #(
   parameter int BLOCK_BITS = 128,
   parameter int KEY_BITS   = 128,
   parameter int TX_GAP     = 1000,
   parameter int RX_TIMEOUT = 50000,
   parameter int MSB_FIRST  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  aes_enable,
   input  logic                  key_reload,
   aes_uart_frame_ctrl_if.master bus,
   output logic                  frames_received,
   output logic                  rx_drop,
   output logic                  rx_timeout
);
   localparam int KEY_BYTES = KEY_BITS / 8;
   localparam int BLK_BYTES = BLOCK_BITS / 8;
   localparam int MAX_BYTES = (KEY_BYTES > BLK_BYTES) ? KEY_BYTES : BLK_BYTES;
   localparam int IDX_W     = $clog2(MAX_BYTES + 1);
   localparam int GAP_W     = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_KEY_RX  = 3'd1,
      S_DATA_RX = 3'd2,
      S_AES     = 3'd3,
      S_TX      = 3'd4,
      S_GAP     = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t                state_q;
   logic                  rx_valid_q;
   logic [IDX_W-1:0]      idx_q;
   logic [GAP_W-1:0]      gap_q;
   logic [KEY_BITS-1:0]   key_q;
   logic [BLOCK_BITS-1:0] block_q;
   logic [BLOCK_BITS-1:0] result_q;
   logic                  tx_start_q;
   logic [7:0]            tx_data_q;
   logic                  aes_start_q;
   logic                  frames_q;
   logic                  drop_q;

   logic                  rx_edge;
   logic [IDX_W-1:0]      key_lane;
   logic [IDX_W-1:0]      blk_lane;

   assign rx_edge  = bus.rx_valid & ~rx_valid_q;
   // Byte index to byte lane; the same lane mapping serves RX storage and TX readout.
   assign key_lane = (MSB_FIRST != 0) ? IDX_W'(KEY_BYTES - 1) - idx_q : idx_q;
   assign blk_lane = (MSB_FIRST != 0) ? IDX_W'(BLK_BYTES - 1) - idx_q : idx_q;

`ifdef AES_UART_RX_TIMEOUT_EN
   localparam int SIL_W = $clog2(RX_TIMEOUT + 1);
   logic [SIL_W-1:0] sil_q;
   logic             timeout_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rx_valid_q  <= 1'b0;
         idx_q       <= '0;
         gap_q       <= '0;
         key_q       <= '0;
         block_q     <= '0;
         result_q    <= '0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         aes_start_q <= 1'b0;
         frames_q    <= 1'b0;
         drop_q      <= 1'b0;
`ifdef AES_UART_RX_TIMEOUT_EN
         sil_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         rx_valid_q  <= bus.rx_valid;
         aes_start_q <= 1'b0;
         drop_q      <= 1'b0;
`ifdef AES_UART_RX_TIMEOUT_EN
         sil_q       <= '0;
         timeout_q   <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               key_q    <= '0;
               block_q  <= '0;
               result_q <= '0;
               idx_q    <= '0;
               frames_q <= 1'b0;
               drop_q   <= rx_edge;
               if (aes_enable) state_q <= S_KEY_RX;
            end
            S_KEY_RX: begin
               if (!aes_enable) begin
                  state_q  <= S_IDLE;
                  idx_q    <= '0;
                  frames_q <= 1'b0;
                  key_q    <= '0;
                  block_q  <= '0;
                  result_q <= '0;
               end else if (rx_edge) begin
                  key_q[8*key_lane +: 8] <= bus.rx_data;
                  if (idx_q == IDX_W'(KEY_BYTES - 1)) begin
                     idx_q    <= '0;
                     frames_q <= 1'b1;
                     state_q  <= S_DATA_RX;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
`ifdef AES_UART_RX_TIMEOUT_EN
               end else if (idx_q != '0) begin
                  if (sil_q == SIL_W'(RX_TIMEOUT - 1)) begin
                     idx_q     <= '0;
                     timeout_q <= 1'b1;
                  end else begin
                     sil_q <= sil_q + 1'b1;
                  end
`endif
               end
            end
            S_DATA_RX: begin
               // Abort takes priority over a coincident byte edge.
               if (!aes_enable) begin
                  state_q  <= S_IDLE;
                  idx_q    <= '0;
                  frames_q <= 1'b0;
                  key_q    <= '0;
                  block_q  <= '0;
                  result_q <= '0;
               end else if (rx_edge) begin
                  block_q[8*blk_lane +: 8] <= bus.rx_data;
                  if (idx_q == IDX_W'(BLK_BYTES - 1)) begin
                     idx_q       <= '0;
                     aes_start_q <= 1'b1;
                     state_q     <= S_AES;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
`ifdef AES_UART_RX_TIMEOUT_EN
               end else if (idx_q != '0) begin
                  if (sil_q == SIL_W'(RX_TIMEOUT - 1)) begin
                     idx_q     <= '0;
                     timeout_q <= 1'b1;
                  end else begin
                     sil_q <= sil_q + 1'b1;
                  end
`endif
               end
            end
            S_AES: begin
               drop_q <= rx_edge;
               if (bus.aes_done) begin
                  result_q <= bus.aes_result;
                  state_q  <= S_TX;
               end
            end
            S_TX: begin
               drop_q <= rx_edge;
               // Request and data are held until the UART signals acceptance by going busy.
               if (!tx_start_q) begin
                  if (bus.tx_ready) begin
                     tx_start_q <= 1'b1;
                     tx_data_q  <= result_q[8*blk_lane +: 8];
                  end
               end else if (!bus.tx_ready) begin
                  tx_start_q <= 1'b0;
                  idx_q      <= idx_q + 1'b1;
                  gap_q      <= '0;
                  state_q    <= S_GAP;
               end
            end
            S_GAP: begin
               drop_q <= rx_edge;
               if (gap_q >= GAP_W'(TX_GAP)) begin
                  if (idx_q == IDX_W'(BLK_BYTES)) begin
                     idx_q   <= '0;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_TX;
                  end
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            S_DONE: begin
               drop_q <= rx_edge;
               if (!aes_enable) begin
                  frames_q <= 1'b0;
                  state_q  <= S_IDLE;
               end else if (key_reload) begin
                  state_q <= S_KEY_RX;
               end else begin
                  state_q <= S_DATA_RX;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.tx_start     = tx_start_q;
   assign bus.tx_data      = tx_data_q;
   assign bus.key_out      = key_q;
   assign bus.block_out    = block_q;
   assign bus.aes_start    = aes_start_q;
   assign frames_received  = frames_q;
   assign rx_drop          = drop_q;
`ifdef AES_UART_RX_TIMEOUT_EN
   assign rx_timeout       = timeout_q;
`else
   assign rx_timeout       = 1'b0;
`endif
endmodule

// File: tb/tb_aes_uart_frame_ctrl.sv
// Randomized scoreboard bench for aes_uart_frame_ctrl with a model UART TX side and model AES core.
// Expected TX bytes and core operands are queued by the stimulus and consumed by monitor processes.
module tb_aes_uart_frame_ctrl;
   localparam int BB   = 128;
   localparam int KB   = 128;
   localparam int GAP  = 8;
   localparam int RXTO = 100;
   localparam int NB   = 16;
`ifdef AES_UART_RX_TIMEOUT_EN
   localparam int EXP_TO = 1;
`else
   localparam int EXP_TO = 0;
`endif

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic aes_enable = 1'b0;
   logic key_reload = 1'b0;
   logic frames_received, rx_drop, rx_timeout;

   aes_uart_frame_ctrl_if #(.BLOCK_BITS(BB), .KEY_BITS(KB)) bus ();

   aes_uart_frame_ctrl #(
      .BLOCK_BITS(BB), .KEY_BITS(KB), .TX_GAP(GAP), .RX_TIMEOUT(RXTO), .MSB_FIRST(1)
   ) dut (
      .clk(clk), .reset(reset), .aes_enable(aes_enable), .key_reload(key_reload),
      .bus(bus), .frames_received(frames_received), .rx_drop(rx_drop), .rx_timeout(rx_timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int tx_cnt = 0;
   int blk_byte = 0;
   int aes_cnt = 0;
   int drop_cnt = 0;
   int to_cnt = 0;
   logic [7:0]   tx_exp[$];
   logic [255:0] kb_exp[$];
   logic [7:0]   sq[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Stand-in core: the real AES answer for the reference vector, a simple mix otherwise.
   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] b);
      if (k == K1 && b == PT1) return CT1;
      return b ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
   endfunction

   function automatic logic [127:0] pack16(input int first);
      logic [127:0] v = '0;
      for (int i = 0; i < NB; i++) v = (v << 8) | 128'(sq[first + i]);
      return v;
   endfunction

   task automatic push_value(input logic [127:0] v);
      for (int i = 0; i < NB; i++) sq.push_back(v[8*(NB-1-i) +: 8]);
   endtask

   task automatic push_random(input int n);
      for (int i = 0; i < n; i++) sq.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic expect_block(input logic [127:0] k, input logic [127:0] b);
      logic [127:0] r;
      r = core_fn(k, b);
      kb_exp.push_back({k, b});
      for (int i = 0; i < NB; i++) tx_exp.push_back(r[8*(NB-1-i) +: 8]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic send_sq(input int from, input int to);
      for (int i = from; i < to; i++) send_byte(sq[i]);
   endtask

   task automatic wait_tx(input int target);
      int n = 0;
      while (tx_cnt < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("tx_complete", 128'(tx_cnt), 128'(target));
      repeat (GAP + 16) @(negedge clk);
   endtask

   // UART TX model and TX scoreboard.
   initial begin
      logic       prev;
      logic [7:0] held;
      logic [7:0] e;
      int         low_cnt;
      int         hold;
      int         busy;
      prev = 1'b0; held = 8'h00; low_cnt = 0; hold = 0; busy = 0;
      bus.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset) begin
            bus.tx_ready = 1'b1;
            prev = 1'b0; low_cnt = 0; blk_byte = 0; busy = 0;
         end else begin
            if (bus.tx_start && !prev) begin
               if (blk_byte != 0) check("tx_gap", 128'(low_cnt >= GAP), 128'(1));
               if (tx_exp.size() == 0) begin
                  total++; bad++;
                  $display("FAIL tx_unexpected: got %h want none", bus.tx_data);
               end else begin
                  e = tx_exp.pop_front();
                  check("tx_data", 128'(bus.tx_data), 128'(e));
               end
               $display("tx byte %0d: data=%h idle_before=%0d", tx_cnt, bus.tx_data, low_cnt);
               held = bus.tx_data;
               hold = $urandom_range(0, 2);
               tx_cnt++;
               blk_byte = (blk_byte + 1) % NB;
            end else if (bus.tx_start) begin
               check("tx_hold", 128'(bus.tx_data), 128'(held));
            end
            if (bus.tx_start) begin
               if (hold == 0) begin
                  bus.tx_ready = 1'b0;
                  busy = $urandom_range(1, 6);
               end else begin
                  hold--;
               end
            end else if (!bus.tx_ready) begin
               if (busy == 0) bus.tx_ready = 1'b1;
               else busy--;
            end
            low_cnt = bus.tx_start ? 0 : low_cnt + 1;
            prev = bus.tx_start;
         end
      end
   end

   // AES core model and operand scoreboard.
   initial begin
      logic [127:0] lk, lb;
      logic [255:0] kb;
      bus.aes_done = 1'b0;
      bus.aes_result = '0;
      forever begin
         @(negedge clk);
         if (reset && bus.aes_start) begin
            aes_cnt++;
            lk = bus.key_out;
            lb = bus.block_out;
            if (kb_exp.size() == 0) begin
               total++; bad++;
               $display("FAIL aes_unexpected: got start with key %h want none", lk);
            end else begin
               kb = kb_exp.pop_front();
               check("aes_key", lk, kb[255:128]);
               check("aes_block", lb, kb[127:0]);
            end
            $display("aes start %0d: key=%h block=%h", aes_cnt, lk, lb);
            @(negedge clk);
            check("aes_start_width", 128'(bus.aes_start), 128'(0));
            repeat (3) @(negedge clk);
            bus.aes_result = core_fn(lk, lb);
            bus.aes_done = 1'b1;
            @(negedge clk);
            bus.aes_done = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            if (rx_drop) drop_cnt++;
            if (rx_timeout) to_cnt++;
         end
      end
   end

   initial begin
      logic [127:0] k2, k3, b2, b3, b5, b6;
      int n;
      bus.rx_data = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_start", 128'(bus.tx_start), 128'(0));
      check("rst_tx_data", 128'(bus.tx_data), 128'(0));
      check("rst_key_out", bus.key_out, 128'(0));
      check("rst_block_out", bus.block_out, 128'(0));
      check("rst_aes_start", 128'(bus.aes_start), 128'(0));
      check("rst_frames", 128'(frames_received), 128'(0));
      check("rst_rx_drop", 128'(rx_drop), 128'(0));
      check("rst_rx_timeout", 128'(rx_timeout), 128'(0));
      reset = 1'b1;
      @(negedge clk);
      aes_enable = 1'b1;

      // Reference vector: key, then block, 16 result bytes back.
      sq.delete(); push_value(K1); send_sq(0, NB);
      check("t1_frames", 128'(frames_received), 128'(1));
      check("t1_key", bus.key_out, K1);
      expect_block(K1, PT1);
      sq.delete(); push_value(PT1); send_sq(0, NB);
      wait_tx(16);

      // Second block on the retained key, stray byte during TX, reload requested.
      sq.delete(); push_random(NB); b2 = pack16(0);
      expect_block(K1, b2);
      send_sq(0, NB);
      key_reload = 1'b1;
      n = 0;
      while (blk_byte != 2 && n < 3000) begin @(negedge clk); n++; end
      check("t2_reach_tx", 128'(blk_byte), 128'(2));
      send_byte(8'($urandom_range(0, 255)));
      repeat (2) @(negedge clk);
      check("t2_rx_drop", 128'(drop_cnt), 128'(1));
      check("t2_block_hold", bus.block_out, b2);
      wait_tx(32);
      check("t2_key_kept", bus.key_out, K1);

      // Fresh key after reload; session stays framed throughout.
      key_reload = 1'b0;
      sq.delete(); push_random(NB); k2 = pack16(0);
      for (int i = 0; i < NB; i++) begin
         send_byte(sq[i]);
         check("t3_frames", 128'(frames_received), 128'(1));
      end
      check("t3_key", bus.key_out, k2);
      sq.delete(); push_random(NB); b3 = pack16(0);
      expect_block(k2, b3);
      send_sq(0, NB);
      wait_tx(48);

      // Abort after 7 data bytes.
      sq.delete(); push_random(7); send_sq(0, 7);
      @(negedge clk);
      aes_enable = 1'b0;
      repeat (2) @(negedge clk);
      check("t4_frames", 128'(frames_received), 128'(0));
      check("t4_block", bus.block_out, 128'(0));
      check("t4_key", bus.key_out, 128'(0));
      aes_enable = 1'b1;

      // Partial frame followed by RX silence.
      sq.delete(); push_random(NB); k3 = pack16(0); send_sq(0, NB);
      check("t6_key", bus.key_out, k3);
      sq.delete(); push_random(NB + 4);
      b6 = (EXP_TO != 0) ? pack16(4) : pack16(0);
      expect_block(k3, b6);
      send_sq(0, 4);
      repeat (RXTO + 10) @(negedge clk);
      check("t6_timeouts", 128'(to_cnt), 128'(EXP_TO));
      if (EXP_TO != 0) send_sq(4, NB + 4);
      else send_sq(4, NB);
      wait_tx(64);

      // Reset while the fourth result byte is being requested.
      sq.delete(); push_random(NB); b5 = pack16(0);
      expect_block(k3, b5);
      send_sq(0, NB);
      n = 0;
      while (n < 3000) begin
         @(negedge clk); #1;
         if (bus.tx_start && blk_byte == 4) break;
         n++;
      end
      check("t5_reach_byte3", 128'(bus.tx_start), 128'(1));
      #1 reset = 1'b0;
      #1;
      check("t5_tx_start_async", 128'(bus.tx_start), 128'(0));
      check("t5_tx_data", 128'(bus.tx_data), 128'(0));
      check("t5_key", bus.key_out, 128'(0));
      check("t5_block", bus.block_out, 128'(0));
      check("t5_frames", 128'(frames_received), 128'(0));
      tx_exp.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("t5_post_tx_start", 128'(bus.tx_start), 128'(0));

      check("end_aes_count", 128'(aes_cnt), 128'(5));
      check("end_kb_left", 128'(kb_exp.size()), 128'(0));
      check("end_drops", 128'(drop_cnt), 128'(1));
      check("end_timeouts", 128'(to_cnt), 128'(EXP_TO));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
